// File: rtl/laser_range_avg_pkg.sv
// Shared types for the laser range averager: FSM state encoding and shot-count sizing.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package laser_range_avg_pkg;

  // Controller states; the encoding is fixed so waveforms read the same across revisions.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FIRE = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // The shot counter gets one spare bit so it exists even when a burst is a single shot.
  function automatic int shot_w(input int log2navg);
    return log2navg + 1;
  endfunction

endpackage

// File: rtl/laser_range_avg_if.sv
// Control/result bundle between the front-end controller and the range averager.
// Latency: n/a (wires only).
// Backpressure: none; valid is a one-cycle pulse, busy tells the master when start is ignored.
interface laser_range_avg_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             clr;
  logic             echo;
  logic             laser;
  logic             busy;
  logic             valid;
  logic             timeout;
  logic [WIDTH-1:0] D;

  modport master (output start, clr, echo, input laser, busy, valid, timeout, D);
  modport slave  (input start, clr, echo, output laser, busy, valid, timeout, D);
endinterface

// File: rtl/laser_range_dp.sv
// Datapath: echo counter, round-trip accumulator, shot counter and distance register.
// Latency: every strobe takes effect on the next rising edge.
// Backpressure: none; the FSM owns all sequencing.
module laser_range_dp
  import laser_range_avg_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int LOG2NAVG = 2,
  parameter int TIMEOUT  = 16'hFFFF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ctr_clr,
  input  logic             ctr_inc,
  input  logic             acc_clr,
  input  logic             acc_add,
  input  logic             d_load,
  input  logic             d_clr,
  output logic             last_shot,
  output logic             at_timeout,
  output logic [WIDTH-1:0] d
);
  localparam int SHOT_W = shot_w(LOG2NAVG);
  localparam int ACC_W  = WIDTH + LOG2NAVG;
  localparam int NAVG   = 1 << LOG2NAVG;

  logic [WIDTH-1:0]  ctr_q;
  logic [ACC_W-1:0]  acc_q;
  logic [SHOT_W-1:0] shot_q;

  // Echo delay counter: zeroed on each shot, advanced while waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ctr_q <= '0;
    else if (ctr_clr) ctr_q <= '0;
    else if (ctr_inc) ctr_q <= ctr_q + 1'b1;
  end

  // Accumulator and shot count move together: every hit adds its delay and counts once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      shot_q <= '0;
    end else if (acc_clr) begin
      acc_q  <= '0;
      shot_q <= '0;
    end else if (acc_add) begin
      acc_q  <= acc_q + ACC_W'(ctr_q);
      shot_q <= shot_q + 1'b1;
    end
  end

  // Published distance: average round trip halved, fractional part dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      d <= '0;
    else if (d_clr)  d <= '0;
    else if (d_load) d <= WIDTH'(acc_q >> (LOG2NAVG + 1));
  end

  assign last_shot  = (shot_q == SHOT_W'(NAVG - 1));
  assign at_timeout = (ctr_q == WIDTH'(TIMEOUT - 1));

endmodule

// File: rtl/laser_range_avg.sv
// Laser range averager: fires NAVG shots, times each echo, publishes (sum/NAVG)/2.
// Latency: start in T -> laser in T+1; valid at T+1+sum(k_i+2)+1.
// Backpressure: start is ignored while busy; clr aborts any burst at once.
module laser_range_avg
  import laser_range_avg_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int LOG2NAVG = 2,
  parameter int TIMEOUT  = 16'hFFFF
) (
  input  logic                clk,
  input  logic                rst_n,
  laser_range_avg_if.slave    bus
);
  state_t     state_q;
  logic       valid_q;
  logic       timeout_q;
  logic       ctr_clr, ctr_inc, acc_clr, acc_add, d_load, d_clr;
  logic       last_shot, at_timeout;
  logic [WIDTH-1:0] d;

  laser_range_dp #(
    .WIDTH    (WIDTH),
    .LOG2NAVG (LOG2NAVG),
    .TIMEOUT  (TIMEOUT)
  ) u_dp (
    .clk        (clk),
    .rst_n      (rst_n),
    .ctr_clr    (ctr_clr),
    .ctr_inc    (ctr_inc),
    .acc_clr    (acc_clr),
    .acc_add    (acc_add),
    .d_load     (d_load),
    .d_clr      (d_clr),
    .last_shot  (last_shot),
    .at_timeout (at_timeout),
    .d          (d)
  );

  // Datapath strobes decoded from the current state; clr wins over everything.
  always_comb begin
    ctr_clr = 1'b0;
    ctr_inc = 1'b0;
    acc_clr = 1'b0;
    acc_add = 1'b0;
    d_load  = 1'b0;
    d_clr   = 1'b0;
    if (bus.clr) begin
      acc_clr = 1'b1;
      d_clr   = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: acc_clr = bus.start;
        S_FIRE: ctr_clr = 1'b1;
        S_WAIT: begin
          if (bus.echo)         acc_add = 1'b1;
          else if (!at_timeout) ctr_inc = 1'b1;
        end
        S_DONE: d_load = 1'b1;
        default: ;
      endcase
    end
  end

  // Controller FSM plus the registered valid pulse and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (bus.clr) begin
        state_q   <= S_IDLE;
        timeout_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (bus.start) begin
              state_q   <= S_FIRE;
              timeout_q <= 1'b0;
            end
          end
          S_FIRE: state_q <= S_WAIT;
          S_WAIT: begin
            // A hit on the last counted cycle still counts; echo beats timeout.
            if (bus.echo) begin
              state_q <= last_shot ? S_DONE : S_FIRE;
            end else if (at_timeout) begin
              timeout_q <= 1'b1;
              state_q   <= S_IDLE;
            end
          end
          S_DONE: begin
            valid_q <= 1'b1;
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.laser   = (state_q == S_FIRE);
  assign bus.busy    = (state_q != S_IDLE);
  assign bus.valid   = valid_q;
  assign bus.timeout = timeout_q;
  assign bus.D       = d;

endmodule

// File: tb/tb_laser_range_avg.sv
// Directed bench for laser_range_avg: one 4-shot instance with a short timeout, one single-shot instance.
// Latency: n/a.
// Backpressure: n/a.
module tb_laser_range_avg;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  laser_range_avg_if #(.WIDTH(16)) a_if ();
  laser_range_avg_if #(.WIDTH(16)) b_if ();

  laser_range_avg #(.WIDTH(16), .LOG2NAVG(2), .TIMEOUT(20)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (a_if.slave)
  );

  laser_range_avg #(.WIDTH(16), .LOG2NAVG(0), .TIMEOUT(16'hFFFF)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b_if.slave)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int t0    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Called in a FIRE cycle; echoes in WAIT cycle k. junk pulses echo during FIRE.
  task automatic shot(input int k, input logic junk);
    chk("laser_fire", 32'(a_if.laser), 32'd1);
    a_if.echo = junk;
    step();
    a_if.echo = 1'b0;
    chk("laser_wait", 32'(a_if.laser), 32'd0);
    repeat (k) step();
    a_if.echo = 1'b1;
    step();
    a_if.echo = 1'b0;
  endtask

  // Launches a 4-shot burst; returns in the DONE cycle.
  task automatic burst4(input int k0, input int k1, input int k2, input int k3);
    a_if.start = 1'b1;
    step();
    a_if.start = 1'b0;
    shot(k0, 1'b0);
    shot(k1, 1'b0);
    shot(k2, 1'b0);
    shot(k3, 1'b0);
  endtask

  initial begin
    a_if.start = 1'b0; a_if.clr = 1'b0; a_if.echo = 1'b0;
    b_if.start = 1'b0; b_if.clr = 1'b0; b_if.echo = 1'b0;
    rst_n = 1'b0;
    step();
    step();
    chk("rst_laser",   32'(a_if.laser),   32'd0);
    chk("rst_busy",    32'(a_if.busy),    32'd0);
    chk("rst_valid",   32'(a_if.valid),   32'd0);
    chk("rst_timeout", 32'(a_if.timeout), 32'd0);
    chk("rst_d",       32'(a_if.D),       32'd0);
    rst_n = 1'b1;
    step();

    // Reset asserted mid-WAIT takes effect without a clock edge.
    a_if.start = 1'b1;
    step();
    a_if.start = 1'b0;
    chk("first_laser", 32'(a_if.laser), 32'd1);
    step();
    step();
    chk("midwait_busy", 32'(a_if.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy",  32'(a_if.busy),  32'd0);
    chk("async_rst_laser", 32'(a_if.laser), 32'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_laser", 32'(a_if.laser), 32'd0);
      chk("post_rst_busy",  32'(a_if.busy),  32'd0);
    end

    // Four echoes at 10: 40 >> 3 = 5.
    burst4(10, 10, 10, 10);
    chk("done_valid", 32'(a_if.valid), 32'd0);
    chk("done_busy",  32'(a_if.busy),  32'd1);
    step();
    chk("avg10_valid", 32'(a_if.valid), 32'd1);
    chk("avg10_d",     32'(a_if.D),     32'd5);
    chk("avg10_busy",  32'(a_if.busy),  32'd0);
    step();
    chk("avg10_valid_drop", 32'(a_if.valid), 32'd0);
    chk("avg10_d_hold",     32'(a_if.D),     32'd5);

    // 3+4+5+6 = 18, 18 >> 3 = 2.
    burst4(3, 4, 5, 6);
    step();
    chk("trunc_valid", 32'(a_if.valid), 32'd1);
    chk("trunc_d",     32'(a_if.D),     32'd2);

    // No echo: abandoned after WAIT k = 19.
    a_if.start = 1'b1;
    step();
    a_if.start = 1'b0;
    chk("to_laser", 32'(a_if.laser), 32'd1);
    step();
    repeat (19) step();
    chk("to_k19_busy",    32'(a_if.busy),    32'd1);
    chk("to_k19_timeout", 32'(a_if.timeout), 32'd0);
    step();
    chk("to_timeout", 32'(a_if.timeout), 32'd1);
    chk("to_busy",    32'(a_if.busy),    32'd0);
    chk("to_valid",   32'(a_if.valid),   32'd0);
    chk("to_d_hold",  32'(a_if.D),       32'd2);
    step();
    chk("to_sticky",  32'(a_if.timeout), 32'd1);
    chk("to_valid2",  32'(a_if.valid),   32'd0);

    // clr in IDLE zeroes the sticky flag and D.
    a_if.clr = 1'b1;
    step();
    a_if.clr = 1'b0;
    chk("clr_idle_timeout", 32'(a_if.timeout), 32'd0);
    chk("clr_idle_d",       32'(a_if.D),       32'd0);

    // Echo on the last allowed cycle is a hit: 4*19 = 76, 76 >> 3 = 9.
    burst4(19, 19, 19, 19);
    step();
    chk("edge_valid",   32'(a_if.valid),   32'd1);
    chk("edge_d",       32'(a_if.D),       32'd9);
    chk("edge_timeout", 32'(a_if.timeout), 32'd0);

    // clr during the second WAIT.
    a_if.start = 1'b1;
    step();
    a_if.start = 1'b0;
    shot(2, 1'b0);
    chk("clr_fire2", 32'(a_if.laser), 32'd1);
    step();
    a_if.clr = 1'b1;
    step();
    a_if.clr = 1'b0;
    chk("clr_busy",    32'(a_if.busy),    32'd0);
    chk("clr_d",       32'(a_if.D),       32'd0);
    chk("clr_timeout", 32'(a_if.timeout), 32'd0);
    chk("clr_valid",   32'(a_if.valid),   32'd0);
    repeat (3) step();
    chk("clr_no_valid", 32'(a_if.valid), 32'd0);
    chk("clr_no_laser", 32'(a_if.laser), 32'd0);

    // start and clr together: nothing launches.
    a_if.start = 1'b1;
    a_if.clr   = 1'b1;
    step();
    a_if.start = 1'b0;
    a_if.clr   = 1'b0;
    chk("startclr_laser", 32'(a_if.laser), 32'd0);
    chk("startclr_busy",  32'(a_if.busy),  32'd0);
    step();
    chk("startclr_laser2", 32'(a_if.laser), 32'd0);

    // start held high: back-to-back bursts; stray echo in FIRE is ignored.
    a_if.start = 1'b1;
    step();
    shot(2, 1'b0);
    shot(2, 1'b0);
    shot(2, 1'b0);
    shot(2, 1'b0);
    step();
    chk("b2b1_valid", 32'(a_if.valid), 32'd1);
    chk("b2b1_d",     32'(a_if.D),     32'd1);
    t0 = cyc;
    step();
    chk("b2b_relaunch", 32'(a_if.laser), 32'd1);
    chk("b2b_d_hold",   32'(a_if.D),     32'd1);
    shot(6, 1'b1);
    shot(6, 1'b1);
    shot(6, 1'b1);
    shot(6, 1'b1);
    a_if.start = 1'b0;
    step();
    chk("b2b2_valid",   32'(a_if.valid), 32'd1);
    chk("b2b2_d",       32'(a_if.D),     32'd3);
    chk("b2b_spacing",  32'(cyc - t0),   32'd34);

    // Echo in IDLE has no effect.
    a_if.echo = 1'b1;
    step();
    a_if.echo = 1'b0;
    chk("idle_echo_busy",  32'(a_if.busy),  32'd0);
    chk("idle_echo_d",     32'(a_if.D),     32'd3);
    chk("idle_echo_valid", 32'(a_if.valid), 32'd0);

    // Single-shot instance: echo at 7 gives 7 >> 1 = 3.
    b_if.start = 1'b1;
    step();
    b_if.start = 1'b0;
    chk("one_laser", 32'(b_if.laser), 32'd1);
    step();
    repeat (7) step();
    b_if.echo = 1'b1;
    step();
    b_if.echo = 1'b0;
    chk("one_done_busy", 32'(b_if.busy), 32'd1);
    step();
    chk("one_valid", 32'(b_if.valid), 32'd1);
    chk("one_d",     32'(b_if.D),     32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
